// File: rtl/ac97_pkg.sv
// Shared constants, state encoding and volume encoder for the AC'97 command sequencer.
// Optional build macro used by dependents: AC97_SEQ_RAMP_EN.
package ac97_pkg;

    localparam logic [6:0]  REG_MASTER    = 7'h02;
    localparam logic [6:0]  REG_HEADPHONE = 7'h04;
    localparam logic [6:0]  REG_PCM_OUT   = 7'h18;
    localparam logic [6:0]  REG_POWERDOWN = 7'h26;

    // Idle word is a harmless read of the powerdown register.
    localparam logic [19:0] IDLE_ADDR     = {1'b1, REG_POWERDOWN, 12'h000};
    localparam logic [15:0] PCM_OUT_0DB   = 16'h0808;

    typedef enum logic [1:0] {
        ST_WAIT_READY = 2'd0,
        ST_INIT_HOLD  = 2'd1,
        ST_IDLE       = 2'd2,
        ST_UPD_HOLD   = 2'd3
    } seq_state_e;

    function automatic logic [15:0] vol_encode(input logic [4:0] vol);
        logic [4:0] atten;
        atten = 5'd31 - vol;
        return {(vol == 5'd0), 2'b00, atten, 3'b000, atten};
    endfunction

    function automatic logic [19:0] wr_addr(input logic [6:0] reg_idx);
        return {1'b0, reg_idx, 12'h000};
    endfunction

    function automatic logic [19:0] data_word(input logic [15:0] data);
        return {data, 4'h0};
    endfunction

endpackage

// File: rtl/ac97_cmd_sequencer.sv
// AC'97 command-slot sequencer: init table after codec ready, then runtime volume writes.
// AC97_SEQ_RAMP_EN: step the applied volume one unit per update write instead of jumping.
//
// state         | meaning
// WAIT_READY    | idle word, waiting for a frame with codec ready
// INIT_HOLD     | holding init-table entry r_idx for HOLD_FRAMES frames
// IDLE          | init complete, idle word, servicing pending volume updates
// UPD_HOLD      | holding a master-volume write for HOLD_FRAMES frames
module ac97_cmd_sequencer
    import ac97_pkg::*;
#(
    parameter int HOLD_FRAMES = 2,
    parameter int NUM_INIT    = 3
) (
    input  logic        i_sysclk,
    input  logic        i_system_reset,
    input  logic        i_frame_done,
    input  logic        i_codec_ready,
    input  logic [4:0]  i_volume,
    input  logic        i_vol_update,
    output logic [19:0] o_cmd_addr,
    output logic [19:0] o_cmd_data,
    output logic        o_busy,
    output logic        o_init_done
);

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam int IDX_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    seq_state_e         r_state, w_state_nxt;
    logic [19:0]        r_cmd_addr, w_addr_nxt;
    logic [19:0]        r_cmd_data, w_data_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_init_done, w_done_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_hold_cnt, w_cnt_nxt;
    logic               r_pending, w_pending_nxt;
    logic [4:0]         r_vol_pending, w_vp_nxt;
    logic [4:0]         w_vol_src;
    logic [IDX_W-1:0]   w_rom_idx;
    logic [19:0]        w_rom_addr;
    logic [19:0]        w_rom_data;
    logic               w_hold_tc;

`ifdef AC97_SEQ_RAMP_EN
    logic [4:0]         r_vol_cur, w_vcur_nxt;
    logic [4:0]         w_vol_step;

    assign w_vol_src  = r_vol_cur;
    assign w_vol_step = (r_vol_cur < r_vol_pending) ? r_vol_cur + 5'd1 :
                        (r_vol_cur > r_vol_pending) ? r_vol_cur - 5'd1 : r_vol_cur;
`else
    assign w_vol_src  = r_vol_pending;
`endif

    // Only two loads ever read the ROM: entry 0 from WAIT_READY, the next entry from INIT_HOLD.
    assign w_rom_idx = (r_state == ST_INIT_HOLD) ? IDX_W'(r_idx + 1'b1) : '0;
    assign w_hold_tc = (r_hold_cnt == CNT_W'(HOLD_FRAMES - 1));

    always_comb begin
        w_rom_addr = wr_addr(REG_PCM_OUT);
        w_rom_data = data_word(PCM_OUT_0DB);
        case (w_rom_idx)
            IDX_W'(0): begin
                w_rom_addr = wr_addr(REG_MASTER);
                w_rom_data = data_word(vol_encode(w_vol_src));
            end
            IDX_W'(1): begin
                w_rom_addr = wr_addr(REG_HEADPHONE);
                w_rom_data = data_word(vol_encode(w_vol_src));
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_cmd_addr;
        w_data_nxt    = r_cmd_data;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_init_done;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_hold_cnt;
        w_pending_nxt = r_pending;
        w_vp_nxt      = r_vol_pending;
`ifdef AC97_SEQ_RAMP_EN
        w_vcur_nxt    = r_vol_cur;
`endif
        case (r_state)
            ST_WAIT_READY: begin
                if (i_frame_done && i_codec_ready) begin
                    w_addr_nxt  = w_rom_addr;
                    w_data_nxt  = w_rom_data;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_INIT_HOLD;
                end
            end
            ST_INIT_HOLD: begin
                if (i_frame_done) begin
                    if (!w_hold_tc) begin
                        w_cnt_nxt = r_hold_cnt + 1'b1;
                    end else if (r_idx < IDX_W'(NUM_INIT - 1)) begin
                        w_addr_nxt = w_rom_addr;
                        w_data_nxt = w_rom_data;
                        w_idx_nxt  = w_rom_idx;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_addr_nxt  = IDLE_ADDR;
                        w_data_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (i_frame_done && r_pending) begin
                    w_addr_nxt    = wr_addr(REG_MASTER);
`ifdef AC97_SEQ_RAMP_EN
                    w_vcur_nxt    = w_vol_step;
                    w_data_nxt    = data_word(vol_encode(w_vol_step));
                    w_pending_nxt = (w_vol_step != r_vol_pending);
`else
                    w_data_nxt    = data_word(vol_encode(r_vol_pending));
                    w_pending_nxt = 1'b0;
`endif
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_UPD_HOLD;
                end
            end
            ST_UPD_HOLD: begin
                if (i_frame_done) begin
                    if (!w_hold_tc) begin
                        w_cnt_nxt = r_hold_cnt + 1'b1;
                    end else begin
                        w_addr_nxt  = IDLE_ADDR;
                        w_data_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_READY;
        endcase
        // A request arriving on a load cycle still re-arms pending with the new value.
        if (i_vol_update) begin
            w_vp_nxt      = i_volume;
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_system_reset) begin
            r_state       <= ST_WAIT_READY;
            r_cmd_addr    <= IDLE_ADDR;
            r_cmd_data    <= '0;
            r_busy        <= 1'b0;
            r_init_done   <= 1'b0;
            r_idx         <= '0;
            r_hold_cnt    <= '0;
            r_pending     <= 1'b0;
            r_vol_pending <= 5'd31;
`ifdef AC97_SEQ_RAMP_EN
            r_vol_cur     <= 5'd31;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_addr    <= w_addr_nxt;
            r_cmd_data    <= w_data_nxt;
            r_busy        <= w_busy_nxt;
            r_init_done   <= w_done_nxt;
            r_idx         <= w_idx_nxt;
            r_hold_cnt    <= w_cnt_nxt;
            r_pending     <= w_pending_nxt;
            r_vol_pending <= w_vp_nxt;
`ifdef AC97_SEQ_RAMP_EN
            r_vol_cur     <= w_vcur_nxt;
`endif
        end
    end

    assign o_cmd_addr  = r_cmd_addr;
    assign o_cmd_data  = r_cmd_data;
    assign o_busy      = r_busy;
    assign o_init_done = r_init_done;

endmodule

// File: tb/tb_ac97_cmd_sequencer.sv
// Randomised + directed bench for ac97_cmd_sequencer against a queue-based command model.
// Honours AC97_SEQ_RAMP_EN when the build defines it.
module tb_ac97_cmd_sequencer;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst, fd, ready, vu;
    logic [4:0]  vol;
    logic [19:0] cmd_addr, cmd_data;
    logic        busy, init_done;

    int n_cmp = 0;
    int n_err = 0;

    ac97_cmd_sequencer #(.HOLD_FRAMES(HOLD), .NUM_INIT(3)) dut (
        .i_sysclk       (clk),
        .i_system_reset (rst),
        .i_frame_done   (fd),
        .i_codec_ready  (ready),
        .i_volume       (vol),
        .i_vol_update   (vu),
        .o_cmd_addr     (cmd_addr),
        .o_cmd_data     (cmd_data),
        .o_busy         (busy),
        .o_init_done    (init_done)
    );

    always #5 clk = ~clk;

    // Reference model: the word on the wire, how many frames it has left, and the
    // init entries still queued behind it.
    logic [19:0] m_addr, m_data;
    bit          m_busy, m_done, m_wait, m_in_init, m_pending;
    int          m_remain, m_vp, m_vcur;
    int          m_q[$];

    function automatic logic [19:0] m_enc(input int v);
        int att;
        int d;
        att = 31 - v;
        d   = att * 257 + ((v == 0) ? 32768 : 0);
        return 20'(d * 16);
    endfunction

    function automatic logic [19:0] m_wr(input int r);
        return 20'(r * 4096);
    endfunction

    task automatic m_reset();
        m_addr = 20'hA6000; m_data = '0; m_busy = 0; m_done = 0; m_wait = 1;
        m_in_init = 0; m_pending = 0; m_remain = 0; m_vp = 31; m_vcur = 31;
        m_q.delete();
    endtask

    task automatic m_load_init(input int k);
        int v;
`ifdef AC97_SEQ_RAMP_EN
        v = m_vcur;
`else
        v = m_vp;
`endif
        case (k)
            0: begin m_addr = m_wr(2);  m_data = m_enc(v); end
            1: begin m_addr = m_wr(4);  m_data = m_enc(v); end
            default: begin m_addr = m_wr(24); m_data = 20'h08080; end
        endcase
        m_busy = 1; m_in_init = 1; m_remain = HOLD;
    endtask

    task automatic m_clock(input bit f, input bit r, input bit u, input int v);
        if (r) begin
            m_reset();
            return;
        end
        if (f) begin
            if (m_wait) begin
                if (ready) begin
                    m_wait = 0;
                    m_q = {1, 2};
                    m_load_init(0);
                end
            end else if (m_busy) begin
                m_remain--;
                if (m_remain == 0) begin
                    if (m_q.size() > 0) begin
                        m_load_init(m_q.pop_front());
                    end else begin
                        m_addr = 20'hA6000; m_data = '0; m_busy = 0;
                        if (m_in_init) m_done = 1;
                        m_in_init = 0;
                    end
                end
            end else if (m_done && m_pending) begin
                m_addr = m_wr(2);
`ifdef AC97_SEQ_RAMP_EN
                if (m_vcur < m_vp) m_vcur++;
                else if (m_vcur > m_vp) m_vcur--;
                m_data = m_enc(m_vcur);
                m_pending = (m_vcur != m_vp);
`else
                m_data = m_enc(m_vp);
                m_pending = 0;
`endif
                m_busy = 1; m_remain = HOLD;
            end
        end
        if (u) begin
            m_vp = v;
            m_pending = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, clock the model, then compare just after the edge.
    task automatic step(input bit f, input bit u, input int v, input bit r);
        @(negedge clk);
        fd = f; vu = u; vol = 5'(v); rst = r;
        @(posedge clk);
        m_clock(f, r, u, v);
        #1;
        chk("addr", cmd_addr, m_addr);
        chk("data", cmd_data, m_data);
        chk("busy", {19'd0, busy}, {19'd0, m_busy});
        chk("done", {19'd0, init_done}, {19'd0, m_done});
    endtask

    task automatic frame(input int gap);
        repeat (gap - 1) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        fd = 0; vu = 0; vol = 0; rst = 1; ready = 0;
        m_reset();
        repeat (3) step(0, 0, 0, 1);
        chk("rst_addr", cmd_addr, 20'hA6000);
        chk("rst_data", cmd_data, 20'h00000);
        chk("rst_busy", {19'd0, busy}, 20'd0);

        // codec not ready: nothing leaves idle
        repeat (10) frame(4);
        chk("nr_addr", cmd_addr, 20'hA6000);
        chk("nr_busy", {19'd0, busy}, 20'd0);

        ready = 1;
        frame(4);
        chk("i0_addr", cmd_addr, 20'h02000);
        chk("i0_data", cmd_data, 20'h00000);
        frame(3);
        chk("i0_hold", cmd_addr, 20'h02000);
        frame(3);
        chk("i1_addr", cmd_addr, 20'h04000);
        frame(3); frame(3);
        chk("i2_addr", cmd_addr, 20'h18000);
        chk("i2_data", cmd_data, 20'h08080);
        frame(3);
        chk("done_early", {19'd0, init_done}, 20'd0);
        ready = 0;  // dropping ready after start must not matter
        frame(3);
        chk("done_set", {19'd0, init_done}, 20'd1);
        chk("post_idle", cmd_addr, 20'hA6000);
        ready = 1;

`ifndef AC97_SEQ_RAMP_EN
        step(0, 1, 16, 0);
        frame(4);
        chk("v16_addr", cmd_addr, 20'h02000);
        chk("v16_data", cmd_data, 20'h0F0F0);
        frame(3);
        chk("v16_hold", cmd_data, 20'h0F0F0);
        frame(3);
        chk("v16_idle", cmd_addr, 20'hA6000);

        step(0, 1, 0, 0);
        frame(4);
        chk("v0_data", cmd_data, 20'h9F1F0);
        frame(3); frame(3);

        step(0, 1, 5, 0);
        step(0, 1, 20, 0);
        frame(3);
        chk("last_wins", cmd_data, 20'h0B0B0);
        frame(3); frame(3); frame(3);
        chk("one_write", {19'd0, busy}, 20'd0);
`else
        step(0, 1, 28, 0);
        frame(3);
        chk("ramp1", cmd_data, 20'h01010);
        frame(3); frame(3); frame(3);
        chk("ramp2", cmd_data, 20'h02020);
        frame(3); frame(3); frame(3);
        chk("ramp3", cmd_data, 20'h03030);
        frame(3); frame(3); frame(3);
        chk("ramp_end", cmd_addr, 20'hA6000);
`endif

        // reset in the middle of the init table, then full replay
        step(0, 0, 0, 1);
        repeat (3) frame(3);
        chk("mid_idx1", cmd_addr, 20'h04000);
        step(0, 0, 0, 1);
        chk("abort_addr", cmd_addr, 20'hA6000);
        chk("abort_done", {19'd0, init_done}, 20'd0);
        repeat (7) frame(3);
        chk("replay_done", {19'd0, init_done}, 20'd1);

        for (int i = 0; i < 4000; i++) begin
            ready = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 31)),
                 $urandom_range(0, 599) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
